segre_main_memory: RTL and testbench



---
 rtl/segre_main_memory.sv | 105 ++++++++++
 tb/tb_segre_main_memory.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/segre_main_memory.sv
// Line-granular main-memory responder for cache refill/writeback: accepts one
// read or write, holds it for LATENCY cycles, then completes with a ready pulse.
module segre_main_memory #(
    parameter int unsigned ADDR_SIZE             = 32,
    parameter int unsigned CACHE_LINE_SIZE_BYTES = 16,
    parameter int unsigned MEM_LINES             = 1024,
    parameter int unsigned LATENCY               = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               rd_i,
    input  logic                               wr_i,
    input  logic [ADDR_SIZE-1:0]               addr_i,
    input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] wr_line_i,
    output logic [CACHE_LINE_SIZE_BYTES*8-1:0] line_o,
    output logic                               ready_o,
    output logic                               busy_o
);

    localparam int unsigned LINE_W = CACHE_LINE_SIZE_BYTES * 8;
    localparam int unsigned OFF    = $clog2(CACHE_LINE_SIZE_BYTES);
    localparam int unsigned IDX    = $clog2(MEM_LINES);
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_wr;
    logic [IDX-1:0]     idx_q;
    logic [LINE_W-1:0]  data_q;
    logic [LINE_W-1:0]  mem [MEM_LINES];
    logic [IDX-1:0]     req_idx;

    // Only the line-index field of the address selects storage; the rest aliases.
    logic unused_addr;
    assign unused_addr = ^addr_i;
    assign req_idx     = addr_i[OFF+IDX-1:OFF];

    // Request FSM: BUSY lasts LATENCY-1 cycles so ready lands LATENCY cycles after acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            op_wr   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
            line_o  <= '0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_i || rd_i) begin
                        op_wr  <= wr_i;
                        idx_q  <= req_idx;
                        data_q <= wr_line_i;
                        cnt    <= CNT_W'(LATENCY - 1);
                        busy_o <= 1'b1;
                        if (LATENCY == 1) begin
                            state   <= DONE;
                            ready_o <= 1'b1;
                            if (!wr_i) begin
                                line_o <= mem[req_idx];
                            end
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state   <= DONE;
                        ready_o <= 1'b1;
                        if (!op_wr) begin
                            line_o <= mem[idx_q];
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Writes commit on the edge leaving DONE; a reset in that cycle discards them.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state == DONE) && op_wr) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_segre_main_memory.sv
// Scoreboarded bench for segre_main_memory: a line-array reference model predicts
// read data and completion cycles; a monitor checks every cycle of the main instance.
module tb_segre_main_memory;

    localparam int unsigned LW = 128;
    localparam int L4 = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          rd_i, wr_i;
    logic [31:0]   addr_i;
    logic [LW-1:0] wr_line_i, line_o;
    logic          ready_o, busy_o;

    logic          rd1, wr1;
    logic [31:0]   addr1;
    logic [LW-1:0] wline1, line1;
    logic          ready1, busy1;

    segre_main_memory #(.ADDR_SIZE(32), .CACHE_LINE_SIZE_BYTES(16), .MEM_LINES(1024), .LATENCY(L4)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .rd_i(rd_i), .wr_i(wr_i), .addr_i(addr_i),
        .wr_line_i(wr_line_i), .line_o(line_o), .ready_o(ready_o), .busy_o(busy_o));

    segre_main_memory #(.ADDR_SIZE(32), .CACHE_LINE_SIZE_BYTES(16), .MEM_LINES(1024), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .rd_i(rd1), .wr_i(wr1), .addr_i(addr1),
        .wr_line_i(wline1), .line_o(line1), .ready_o(ready1), .busy_o(busy1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit            is_rd;
        logic [LW-1:0] data;
        int            rdy;
    } exp_t;

    exp_t          q[$];
    logic [LW-1:0] ref_mem [int];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int line_idx(input logic [31:0] a);
        return int'((a >> 4) & 32'd1023);
    endfunction

    function automatic logic [LW-1:0] model_rd(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : '0;
    endfunction

    // Monitor: busy window, completion cycle and read data for the main instance.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   have;
            bit   exp_busy;
            exp_t e;
            have     = (q.size() > 0);
            exp_busy = have && (cyc >= q[0].rdy - (L4 - 1)) && (cyc <= q[0].rdy);
            chk("busy_o", LW'(busy_o), LW'(exp_busy));
            if (ready_o) begin
                if (!have) begin
                    chk("spurious ready_o", LW'(1), LW'(0));
                end else begin
                    e = q.pop_front();
                    chk("ready cycle", LW'(cyc), LW'(e.rdy));
                    if (e.is_rd) chk("line_o", line_o, e.data);
                end
            end else if (have && cyc >= q[0].rdy) begin
                e = q.pop_front();
                chk("missing ready_o", LW'(0), LW'(1));
            end
        end
    end

    // Issue one transaction from a negedge in IDLE; returns at a negedge in IDLE.
    task automatic txn(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [LW-1:0] data, input bit scramble, input bit keep_rd);
        exp_t e;
        int   idx;
        int   n;
        idx       = line_idx(addr);
        wr_i      = wr;
        rd_i      = rd;
        addr_i    = addr;
        wr_line_i = data;
        e.is_rd   = !wr;
        e.rdy     = cyc + L4;
        if (wr) ref_mem[idx] = data;
        e.data = model_rd(idx);
        q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scramble && !ready_o) begin
                addr_i    = 32'($urandom_range(0, 127)) << 4;
                wr_line_i = {$urandom, $urandom, $urandom, $urandom};
            end
        end while (!ready_o && n < 20);
        if (!ready_o) begin
            chk("ready_o timeout", LW'(0), LW'(1));
            q.delete();
        end
        wr_i = 1'b0;
        if (!keep_rd) rd_i = 1'b0;
        @(negedge clk);
    endtask

    // Write aborted by reset k cycles after the drive negedge; the model is untouched.
    task automatic aborted_write(input logic [31:0] addr, input logic [LW-1:0] data, input int k);
        mon_en    = 1'b0;
        wr_i      = 1'b1;
        addr_i    = addr;
        wr_line_i = data;
        repeat (k) @(negedge clk);
        rst_i = 1'b1;
        wr_i  = 1'b0;
        @(negedge clk);
        chk("rst ready_o", LW'(ready_o), LW'(0));
        chk("rst busy_o", LW'(busy_o), LW'(0));
        chk("rst line_o", line_o, '0);
        rst_i = 1'b0;
        repeat (L4 + 1) begin
            @(negedge clk);
            chk("post-rst ready_o", LW'(ready_o), LW'(0));
        end
        mon_en = 1'b1;
    endtask

    initial begin
        logic [LW-1:0] d;
        logic [31:0]   a;
        int            c0;
        int            n;
        rst_i = 1'b1; rd_i = 0; wr_i = 0; addr_i = '0; wr_line_i = '0;
        rd1 = 0; wr1 = 0; addr1 = '0; wline1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready_o", LW'(ready_o), LW'(0));
        chk("reset busy_o", LW'(busy_o), LW'(0));
        chk("reset line_o", line_o, '0);
        chk("reset line_o L1", line1, '0);
        rst_i = 1'b0;
        @(negedge clk);

        // LATENCY=1 instance: write a line, then hold a read for back-to-back completions.
        d = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        wr1 = 1'b1; addr1 = 32'h40; wline1 = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready1 && n < 10);
        chk("L1 write ready", LW'(ready1), LW'(1));
        wr1 = 1'b0;
        @(negedge clk);
        rd1 = 1'b1;
        c0  = cyc;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("L1 ready_o", LW'(ready1), LW'((cyc - c0) % 2 == 1));
            chk("L1 busy_o", LW'(busy1), LW'((cyc - c0) % 2 == 1));
            if ((cyc - c0) % 2 == 1) chk("L1 line_o", line1, d);
        end
        rd1 = 1'b0;
        @(negedge clk);

        mon_en = 1'b1;
        for (int i = 0; i < 128; i++) txn(1'b1, 1'b0, 32'(i) << 4, '0, 1'b0, 1'b0);

        // Write 0x100 with bytes 0..15, read back through an in-line offset.
        for (int b = 0; b < 16; b++) d[b*8 +: 8] = 8'(b);
        txn(1'b1, 1'b0, 32'h100, d, 1'b0, 1'b0);
        txn(1'b0, 1'b1, 32'h104, '0, 1'b0, 1'b0);

        // Simultaneous rd/wr: write wins, held read follows.
        d = {16{8'hAA}};
        txn(1'b1, 1'b1, 32'h200, d, 1'b0, 1'b1);
        txn(1'b0, 1'b1, 32'h200, '0, 1'b0, 1'b0);

        // Aliasing modulo 16 KiB.
        txn(1'b1, 1'b0, 32'h4000, {16{8'h55}}, 1'b0, 1'b0);
        txn(1'b0, 1'b1, 32'h0000, '0, 1'b0, 1'b0);

        // Inputs scrambled after acceptance must not disturb the captured write.
        txn(1'b1, 1'b0, 32'h300, 128'hdeadbeef_01234567_89abcdef_cafef00d, 1'b1, 1'b0);
        txn(1'b0, 1'b1, 32'h300, '0, 1'b0, 1'b0);
        for (int i = 40; i < 56; i++) txn(1'b0, 1'b1, 32'(i) << 4, '0, 1'b0, 1'b0);

        // Reset two cycles into a write, then in its DONE cycle.
        aborted_write(32'h500, {16{8'hFF}}, 2);
        txn(1'b0, 1'b1, 32'h500, '0, 1'b0, 1'b0);
        aborted_write(32'h600, {16{8'h77}}, L4);
        txn(1'b0, 1'b1, 32'h600, '0, 1'b0, 1'b0);

        // Random traffic with aliased upper bits and random offsets.
        for (int i = 0; i < 60; i++) begin
            a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 127)) << 4) | ($urandom & 32'hF);
            d = {$urandom, $urandom, $urandom, $urandom};
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) | 1'b1, a, d,
                1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (L4 + 2) @(negedge clk);
        chk("scoreboard drained", LW'(q.size()), LW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
